wca_cic_interp: RTL and testbench

WCA_CIC_INTERP -- requirements
Module: wca_cic_interp

---
 rtl/wca_cic_pkg.sv | 20 ++
 rtl/wca_cic_shift_sat.sv | 38 +++
 rtl/wca_cic_interp.sv | 122 ++++++++++++
 tb/tb_wca_cic_interp.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wca_cic_pkg.sv
// Shared constants and helpers for the CIC interpolator.
// Accumulator width and output clamp limits live here.
package wca_cic_pkg;

  localparam int N_STAGES = 3;
  localparam int GROWTH   = 16;

  function automatic int acc_w(input int width);
    return width + GROWTH;
  endfunction

  function automatic longint sat_pos(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sat_neg(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/wca_cic_shift_sat.sv
// Rate-dependent gain removal and reduction to the output width.
// WCA_CIC_SATURATE_EN selects clamping; otherwise low bits wrap.
import wca_cic_pkg::*;

module wca_cic_shift_sat #(
  parameter int WIDTH = 12,
  parameter int ACC_W = acc_w(12)
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [3:0]       log2_rate,
  output logic signed [WIDTH-1:0] dout
);

`ifdef WCA_CIC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic signed [ACC_W-1:0] POS =
    ACC_W'(sat_pos(WIDTH));
  localparam logic signed [ACC_W-1:0] NEG =
    ACC_W'(sat_neg(WIDTH));

  logic signed [ACC_W-1:0] sh;

  // gain of an N=3 interpolator is R^2, so shift by 2*log2(R)
  assign sh = acc >>> {log2_rate, 1'b0};

  always_comb begin
    dout = sh[WIDTH-1:0];
    if (SAT && sh > POS)
      dout = POS[WIDTH-1:0];
    else if (SAT && sh < NEG)
      dout = NEG[WIDTH-1:0];
  end

endmodule

// File: rtl/wca_cic_interp.sv
// Three-stage CIC interpolator for an I/Q pair.
// Output reduction chosen by WCA_CIC_SATURATE_EN.
import wca_cic_pkg::*;

module wca_cic_interp #(
  parameter int WIDTH    = 12,
  parameter int N_STAGES = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    aclr,
  input  logic                    bypass,
  input  logic                    strobe_in,
  input  logic                    strobe_hi,
  input  logic        [3:0]       log2_rate,
  input  logic signed [WIDTH-1:0] din_i,
  input  logic signed [WIDTH-1:0] din_q,
  output logic signed [WIDTH-1:0] dout_i,
  output logic signed [WIDTH-1:0] dout_q,
  output logic                    strobe_out,
  output logic                    overrun
);

  localparam int AW = acc_w(WIDTH);
  localparam int NS =
    (N_STAGES == wca_cic_pkg::N_STAGES) ?
    N_STAGES : wca_cic_pkg::N_STAGES;

  typedef logic signed [AW-1:0] acc_t;

  acc_t din_x   [2];
  acc_t dly     [2][NS];
  acc_t stg_in  [2][NS];
  acc_t comb_nx [2];
  acc_t comb_q  [2];
  acc_t integ   [2][NS];
  acc_t feed    [2];
  acc_t i3_nx   [2];
  logic signed [WIDTH-1:0] red [2];
  logic pending;

  assign din_x[0] = acc_t'(din_i);
  assign din_x[1] = acc_t'(din_q);

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      acc_t v;
      v = din_x[c];
      for (int s = 0; s < NS; s++) begin
        stg_in[c][s] = v;
        v = v - dly[c][s];
      end
      comb_nx[c] = v;
      feed[c]  = pending ? comb_q[c] : '0;
      i3_nx[c] = integ[c][NS-1] + integ[c][NS-2];
    end
  end

  wca_cic_shift_sat #(.WIDTH(WIDTH), .ACC_W(AW)) u_ss_i (
    .acc       (i3_nx[0]),
    .log2_rate (log2_rate),
    .dout      (red[0])
  );

  wca_cic_shift_sat #(.WIDTH(WIDTH), .ACC_W(AW)) u_ss_q (
    .acc       (i3_nx[1]),
    .log2_rate (log2_rate),
    .dout      (red[1])
  );

  always_ff @(posedge clock) begin
    if (reset || aclr) begin
      for (int c = 0; c < 2; c++) begin
        comb_q[c] <= '0;
        for (int s = 0; s < NS; s++) begin
          dly[c][s]   <= '0;
          integ[c][s] <= '0;
        end
      end
      pending    <= 1'b0;
      overrun    <= 1'b0;
      dout_i     <= '0;
      dout_q     <= '0;
      strobe_out <= 1'b0;
    end else begin
      strobe_out <= 1'b0;
      if (enable && bypass) begin
        if (strobe_in) begin
          dout_i     <= din_i;
          dout_q     <= din_q;
          strobe_out <= 1'b1;
        end
      end else if (enable) begin
        if (strobe_in) begin
          for (int c = 0; c < 2; c++) begin
            comb_q[c] <= comb_nx[c];
            for (int s = 0; s < NS; s++)
              dly[c][s] <= stg_in[c][s];
          end
          pending <= 1'b1;
          // an unconsumed sample is being replaced
          if (pending && !strobe_hi)
            overrun <= 1'b1;
        end else if (strobe_hi) begin
          pending <= 1'b0;
        end
        if (strobe_hi) begin
          for (int c = 0; c < 2; c++) begin
            integ[c][0] <= integ[c][0] + feed[c];
            for (int s = 1; s < NS; s++)
              integ[c][s] <= integ[c][s] + integ[c][s-1];
          end
          dout_i     <= red[0];
          dout_q     <= red[1];
          strobe_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wca_cic_interp.sv
// Randomized bench for wca_cic_interp against a convolution model.
// Build with WCA_CIC_SATURATE_EN to match a clamping DUT.
module tb_wca_cic_interp;

  localparam int W  = 12;
  localparam int AW = W + 16;

  logic clock = 1'b0;
  logic reset, enable, aclr, bypass;
  logic strobe_in, strobe_hi;
  logic [3:0] log2_rate;
  logic signed [W-1:0] din_i, din_q;
  logic signed [W-1:0] dout_i, dout_q;
  logic strobe_out, overrun;

  int total = 0;
  int bad   = 0;

  wca_cic_interp #(.WIDTH(W), .N_STAGES(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .aclr       (aclr),
    .bypass     (bypass),
    .strobe_in  (strobe_in),
    .strobe_hi  (strobe_hi),
    .log2_rate  (log2_rate),
    .din_i      (din_i),
    .din_q      (din_q),
    .dout_i     (dout_i),
    .dout_q     (dout_q),
    .strobe_out (strobe_out),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  // model: sample history, zero-stuffed high-rate stream, outputs
  longint hist [2][3];
  longint xs0 [$];
  longint xs1 [$];
  longint pval [2];
  bit     m_pend, m_ovr, m_so;
  longint m_di, m_dq;

  task automatic chk(string tag, longint got, longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic longint reduce(longint y, int lr);
    longint a;
    a = (y <<< (64 - AW)) >>> (64 - AW);
    a = a >>> (2 * lr);
`ifdef WCA_CIC_SATURATE_EN
    if (a > 2047) return 2047;
    if (a < -2048) return -2048;
    return a;
`else
    return (a <<< (64 - W)) >>> (64 - W);
`endif
  endfunction

  // three cascaded integrators with one-cycle stage pipelining:
  // impulse response after k events is k*(k-1)/2
  function automatic longint integ_out(longint xs [$]);
    longint y;
    int k;
    y = 0;
    k = xs.size() - 1;
    for (int j = 0; j <= k; j++)
      y += xs[j] * (longint'(k - j) * (k - j - 1) / 2);
    return y;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < 2; c++) begin
      pval[c] = 0;
      for (int s = 0; s < 3; s++) hist[c][s] = 0;
    end
    xs0.delete();
    xs1.delete();
    m_pend = 0; m_ovr = 0; m_so = 0;
    m_di = 0; m_dq = 0;
  endtask

  task automatic model_step();
    longint x [2];
    bit old_pend;
    x[0] = din_i;
    x[1] = din_q;
    if (reset || aclr) begin
      clear_model();
      return;
    end
    m_so = 0;
    if (!enable) return;
    if (bypass) begin
      if (strobe_in) begin
        m_di = x[0]; m_dq = x[1]; m_so = 1;
      end
      return;
    end
    old_pend = m_pend;
    if (strobe_hi) begin
      xs0.push_back(old_pend ? pval[0] : 0);
      xs1.push_back(old_pend ? pval[1] : 0);
      m_di = reduce(integ_out(xs0), int'(log2_rate));
      m_dq = reduce(integ_out(xs1), int'(log2_rate));
      m_so = 1;
      m_pend = 0;
    end
    if (strobe_in) begin
      for (int c = 0; c < 2; c++) begin
        pval[c] = x[c] - 3 * hist[c][0]
                + 3 * hist[c][1] - hist[c][2];
        hist[c][2] = hist[c][1];
        hist[c][1] = hist[c][0];
        hist[c][0] = x[c];
      end
      if (old_pend && !strobe_hi) m_ovr = 1;
      m_pend = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("strobe_out", strobe_out, m_so);
    chk("dout_i", dout_i, m_di);
    chk("dout_q", dout_q, m_dq);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic idle_inputs();
    reset = 0; aclr = 0; enable = 1; bypass = 0;
    strobe_in = 0; strobe_hi = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic run_rate(int n, int r, longint di, longint dq);
    for (int i = 0; i < n; i++) begin
      strobe_hi = 1;
      strobe_in = (i % r) == 0;
      din_i = W'(di);
      din_q = W'(dq);
      tick();
    end
    strobe_in = 0;
    strobe_hi = 0;
  endtask

  longint imp [$];

  initial begin
    idle_inputs();
    log2_rate = 0;
    din_i = 0;
    din_q = 0;
    clear_model();
    reset = 1;
    tick();
    tick();
    reset = 0;

    // DC settles to input value at rate 4
    log2_rate = 2;
    run_rate(60, 4, 100, -37);
    chk("dc_i", dout_i, 100);
    chk("dc_q", dout_q, -37);

    // reset in the middle of a DC run
    run_rate(7, 4, 100, -37);
    do_reset();
    chk("rst_dout", dout_i, 0);
    chk("rst_so", strobe_out, 0);
    run_rate(60, 4, 100, -37);
    chk("dc_again", dout_i, 100);

    // impulse at rate 2
    do_reset();
    log2_rate = 1;
    imp.delete();
    for (int i = 0; i < 24; i++) begin
      strobe_hi = 1;
      strobe_in = (i % 2) == 0;
      din_i = (i == 0) ? W'(16) : W'(0);
      din_q = 0;
      tick();
      if (strobe_out && dout_i != 0) imp.push_back(dout_i);
    end
    chk("imp_n", imp.size(), 4);
    chk("imp0", imp.size() > 0 ? imp[0] : -999, 4);
    chk("imp1", imp.size() > 1 ? imp[1] : -999, 12);
    chk("imp2", imp.size() > 2 ? imp[2] : -999, 12);
    chk("imp3", imp.size() > 3 ? imp[3] : -999, 4);

    // overflow at rate 3 with near-full-scale input
    do_reset();
    log2_rate = 1;
    run_rate(60, 3, 2047, -2048);
`ifdef WCA_CIC_SATURATE_EN
    chk("sat_i", dout_i, 2047);
    chk("sat_q", dout_q, -2048);
`endif

    // overrun then aclr
    do_reset();
    strobe_in = 1; din_i = 55;
    tick();
    tick();
    strobe_in = 0;
    chk("ovr_set", overrun, 1);
    aclr = 1;
    tick();
    aclr = 0;
    chk("ovr_clr", overrun, 0);
    chk("aclr_dout", dout_q, 0);

    // bypass passes the sample and leaves the filter alone
    log2_rate = 2;
    run_rate(20, 4, 300, 80);
    bypass = 1; strobe_in = 1; din_q = -5;
    tick();
    strobe_in = 0;
    chk("byp_q", dout_q, -5);
    chk("byp_so", strobe_out, 1);
    strobe_hi = 1;
    tick();
    chk("byp_hold", strobe_out, 0);
    bypass = 0;
    run_rate(20, 4, 300, 80);

    // enable low holds everything
    enable = 0; strobe_in = 1; strobe_hi = 1;
    tick();
    tick();
    enable = 1;
    strobe_in = 0; strobe_hi = 0;

    // randomized traffic with mid-stream rate changes
    do_reset();
    for (int i = 0; i < 600; i++) begin
      strobe_in = $urandom_range(0, 3) == 0;
      strobe_hi = $urandom_range(0, 1) == 1;
      enable    = $urandom_range(0, 15) != 0;
      bypass    = $urandom_range(0, 31) == 0;
      aclr      = $urandom_range(0, 149) == 0;
      if ($urandom_range(0, 49) == 0)
        log2_rate = 4'($urandom_range(0, 7));
      din_i = W'($urandom);
      din_q = W'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
